// File: rtl/wb_arbiter_pkg.sv
// Shared types, register-file constants and helpers for the writeback arbiter.
// Optional feature macro: WB_RR_ARB_EN (round-robin arbitration instead of fixed priority).
// The shared register-file defines (RegBus, RegAddrBus, ZeroReg) live here, guarded, so
// every file that imports the package sees one definition.

`ifndef RegBus
`define RegBus 63:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef ZeroReg
`define ZeroReg 5'd0
`endif

package wb_arbiter_pkg;

  typedef logic [`RegBus]     reg_t;
  typedef logic [`RegAddrBus] reg_addr_t;

  localparam int unsigned REG_W      = $bits(reg_t);
  localparam int unsigned REG_ADDR_W = $bits(reg_addr_t);
  localparam reg_addr_t   ZERO_REG   = `ZeroReg;

  typedef enum logic {
    ArbFixed,
    ArbRoundRobin
  } arb_mode_e;

  // Index width for a requester count, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: requester-side handshake plus register-file write port.
// Optional feature macro: WB_RR_ARB_EN (affects arbitration policy only, not this bundle).

interface wb_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned CNT_W   = 16
);
  import wb_arbiter_pkg::*;

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_we_i;
  logic [NUM_REQ*REG_ADDR_W-1:0] req_waddr_i;
  logic [NUM_REQ*REG_W-1:0]      req_wdata_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          reg_we_o;
  reg_addr_t                     reg_waddr_o;
  reg_t                          reg_wdata_o;
  logic                          busy_o;
  logic [CNT_W-1:0]              conflict_cnt_o;

  // Producer side (execute/memory units, or a bench driver).
  modport master (
    output req_valid_i, req_we_i, req_waddr_i, req_wdata_i,
    input  req_ready_o, reg_we_o, reg_waddr_o, reg_wdata_o, busy_o, conflict_cnt_o
  );

  // Arbiter side.
  modport slave (
    input  req_valid_i, req_we_i, req_waddr_i, req_wdata_i,
    output req_ready_o, reg_we_o, reg_waddr_o, reg_wdata_o, busy_o, conflict_cnt_o
  );

endinterface

// File: rtl/wb_arb_pick.sv
// Combinational picker: first valid requester found searching upward from start, wrapping.
// A start of zero gives plain lowest-index-wins priority.

module wb_arb_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   start,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Rotating search: first hit from start wins, later hits are ignored.
  always_comb begin
    int unsigned k;
    k     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      k = int'(start) + off;
      if (k >= NUM_REQ) begin
        k = k - NUM_REQ;
      end
      if (!any && valid[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the register-file write port between NUM_REQ producers.
// Grant is combinational; the winning write is registered for one cycle, x0 writes dropped.
// Optional feature macro: WB_RR_ARB_EN selects round-robin; default is fixed priority.

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned CNT_W   = 16
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
`ifdef WB_RR_ARB_EN
  localparam arb_mode_e ARB_MODE = ArbRoundRobin;
`else
  localparam arb_mode_e ARB_MODE = ArbFixed;
`endif

  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   pick_start;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_any;
  logic               grant_en;
  logic               multi_valid;
  reg_addr_t          sel_waddr;
  reg_t               sel_wdata;
  logic               sel_we;
  logic               reg_we_q;
  reg_addr_t          reg_waddr_q;
  reg_t               reg_wdata_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // The rr pointer only steers the search in round-robin mode.
  assign pick_start = (ARB_MODE == ArbRoundRobin) ? rr_q : '0;

  wb_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid (bus.req_valid_i),
    .start (pick_start),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // No grant while reset is asserted, so an in-flight handshake is discarded.
  assign grant_en        = pick_any & ~rst;
  assign bus.req_ready_o = grant_en ? pick_grant : '0;
  assign bus.busy_o      = pick_any & ~rst;

  // Slice muxes for the winning requester.
  assign sel_waddr = bus.req_waddr_i[int'(pick_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign sel_wdata = bus.req_wdata_i[int'(pick_idx)*REG_W +: REG_W];
  assign sel_we    = bus.req_we_i[pick_idx];

  // Next rr pointer: one past the winner, wrapping; unchanged without a grant.
  always_comb begin
    rr_d = rr_q;
    if (grant_en) begin
      rr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  // Contention detect: a second valid bit seen after a first one.
  always_comb begin
    logic seen;
    seen        = 1'b0;
    multi_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (bus.req_valid_i[k]) begin
        if (seen) begin
          multi_valid = 1'b1;
        end
        seen = 1'b1;
      end
    end
  end

  // Saturating contention counter next state.
  always_comb begin
    cnt_d = cnt_q;
    if (multi_valid && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Arbitration state: rr pointer and contention counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

  // Registered write port: address/data load on every grant and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
    end else begin
      reg_we_q <= grant_en & sel_we & (sel_waddr != ZERO_REG);
      if (grant_en) begin
        reg_waddr_q <= sel_waddr;
        reg_wdata_q <= sel_wdata;
      end
    end
  end

  assign bus.reg_we_o       = reg_we_q;
  assign bus.reg_waddr_o    = reg_waddr_q;
  assign bus.reg_wdata_o    = reg_wdata_q;
  assign bus.conflict_cnt_o = cnt_q;

endmodule
